// File: rtl/text_line_ctrl.sv
// Write sequencer for the VGA text line buffer: round-robin arbitration of two
// character sources, command decode into single-entry writes, cursor/fill tracking.
module text_line_ctrl #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CODE_W  = 7,
    parameter int unsigned WRAP_EN = 0
) (
    input  logic                       clk_50,
    input  logic                       reset,
    input  logic                       req0,
    input  logic [1:0]                 op0,
    input  logic [CODE_W-1:0]          code0,
    output logic                       ack0,
    input  logic                       req1,
    input  logic [1:0]                 op1,
    input  logic [CODE_W-1:0]          code1,
    output logic                       ack1,
    output logic                       wr_en,
    output logic [$clog2(DEPTH)-1:0]   wr_addr,
    output logic [CODE_W-1:0]          wr_data,
    output logic [$clog2(DEPTH)-1:0]   cursor,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       busy,
    output logic                       overflow
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    localparam logic [1:0] OP_CHAR = 2'b00;
    localparam logic [1:0] OP_BS   = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACK   = 2'b01,
        CLEAR = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic                last_gnt, last_gnt_d;
    logic [ADDR_W-1:0]   clr_idx, clr_idx_d;
    logic [ADDR_W-1:0]   cursor_d;
    logic [CNT_W-1:0]    count_d;
    logic                ack0_d, ack1_d, wr_en_d, overflow_d, busy_d, full_d;
    logic [ADDR_W-1:0]   wr_addr_d;
    logic [CODE_W-1:0]   wr_data_d;
    logic                gnt;
    logic [1:0]          sel_op;
    logic [CODE_W-1:0]   sel_code;

    // On a tie the port that did not win the last tie is granted
    always_comb begin
        gnt      = (req0 && req1) ? ~last_gnt : req1;
        sel_op   = gnt ? op1 : op0;
        sel_code = gnt ? code1 : code0;
    end

    // Next-state and next-output decode
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt;
        clr_idx_d  = clr_idx;
        cursor_d   = cursor;
        count_d    = count;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = '0;
        wr_data_d  = '0;
        overflow_d = 1'b0;
        busy_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    if (req0 && req1) begin
                        last_gnt_d = gnt;
                    end
                    ack0_d  = ~gnt;
                    ack1_d  = gnt;
                    busy_d  = 1'b1;
                    state_d = ACK;
                    unique case (sel_op)
                        OP_CHAR: begin
                            if (!full || (WRAP_EN != 0)) begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = cursor;
                                wr_data_d = sel_code;
                                cursor_d  = cursor + ADDR_W'(1);
                                if (count != FULL_CNT) begin
                                    count_d = count + CNT_W'(1);
                                end
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end
                        OP_BS: begin
                            if (count != '0) begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = cursor - ADDR_W'(1);
                                cursor_d  = cursor - ADDR_W'(1);
                                count_d   = count - CNT_W'(1);
                            end
                        end
                        OP_CLR: begin
                            state_d   = CLEAR;
                            clr_idx_d = '0;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            CLEAR: begin
                // busy stays up through the final blanking write
                busy_d    = 1'b1;
                wr_en_d   = 1'b1;
                wr_addr_d = clr_idx;
                clr_idx_d = clr_idx + ADDR_W'(1);
                if (clr_idx == LAST_IDX) begin
                    state_d  = IDLE;
                    cursor_d = '0;
                    count_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        full_d = (count_d == FULL_CNT);
    end

    // State and registered outputs
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_gnt <= 1'b1;
            clr_idx  <= '0;
            cursor   <= '0;
            count    <= '0;
            full     <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_gnt <= last_gnt_d;
            clr_idx  <= clr_idx_d;
            cursor   <= cursor_d;
            count    <= count_d;
            full     <= full_d;
            ack0     <= ack0_d;
            ack1     <= ack1_d;
            wr_en    <= wr_en_d;
            wr_addr  <= wr_addr_d;
            wr_data  <= wr_data_d;
            overflow <= overflow_d;
            busy     <= busy_d;
        end
    end

endmodule
